// File: rtl/lcd_timing_gen_if.sv
// Panel-side raster outputs of lcd_timing_gen: pixel enable, coordinates, syncs and frame markers.
// The generator drives the master side; pixel-colour generators and pin drivers use the slave side.
interface lcd_timing_gen_if;
    logic        DEN;
    logic [10:0] X;
    logic [10:0] Y;
    logic        HSYNC_N;
    logic        VSYNC_N;
    logic        LINE_END;
    logic        FRAME_START;
    logic [15:0] FRAME_CNT;

    modport master (
        output DEN, X, Y, HSYNC_N, VSYNC_N, LINE_END, FRAME_START, FRAME_CNT
    );

    modport slave (
        input DEN, X, Y, HSYNC_N, VSYNC_N, LINE_END, FRAME_START, FRAME_CNT
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Free-running raster timing generator for a parallel RGB LCD.
// Every output is a registered decode of the current (hcnt, vcnt) position.
module lcd_timing_gen #(
    parameter int unsigned LCD_WIDTH  = 480,
    parameter int unsigned LCD_HEIGHT = 280,
    parameter int unsigned H_FP       = 8,
    parameter int unsigned H_SYNC     = 4,
    parameter int unsigned H_BP       = 43,
    parameter int unsigned V_FP       = 4,
    parameter int unsigned V_SYNC     = 4,
    parameter int unsigned V_BP       = 12
) (
    input  logic             CLK,
    input  logic             nRST,
    lcd_timing_gen_if.master lcd
);

    // Both totals must fit the 11-bit counters (<= 2048).
    localparam int unsigned H_TOTAL = LCD_WIDTH + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = LCD_HEIGHT + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast    = 11'(V_TOTAL - 1);
    // Window bounds are kept 12 bits wide so an end bound of 2048 cannot alias to 0.
    localparam logic [11:0] HActive  = 12'(LCD_WIDTH);
    localparam logic [11:0] VActive  = 12'(LCD_HEIGHT);
    localparam logic [11:0] HSyncLo  = 12'(LCD_WIDTH + H_FP);
    localparam logic [11:0] HSyncHi  = 12'(LCD_WIDTH + H_FP + H_SYNC);
    localparam logic [11:0] VSyncLo  = 12'(LCD_HEIGHT + V_FP);
    localparam logic [11:0] VSyncHi  = 12'(LCD_HEIGHT + V_FP + V_SYNC);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        den_q, den_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        line_end_q, line_end_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [11:0] h_ext;
    logic [11:0] v_ext;
    logic        line_wrap;

    always_comb begin
        line_wrap = (hcnt_q == HLast);
        hcnt_d    = line_wrap ? 11'd0 : hcnt_q + 11'd1;
        vcnt_d    = vcnt_q;
        if (line_wrap) begin
            vcnt_d = (vcnt_q == VLast) ? 11'd0 : vcnt_q + 11'd1;
        end
    end

    always_comb begin
        h_ext         = {1'b0, hcnt_q};
        v_ext         = {1'b0, vcnt_q};
        den_d         = (h_ext < HActive) && (v_ext < VActive);
        x_d           = den_d ? hcnt_q : 11'd0;
        y_d           = den_d ? vcnt_q : 11'd0;
        hsync_n_d     = !((h_ext >= HSyncLo) && (h_ext < HSyncHi));
        vsync_n_d     = !((v_ext >= VSyncLo) && (v_ext < VSyncHi));
        line_end_d    = line_wrap;
        frame_start_d = (hcnt_q == 11'd0) && (vcnt_q == 11'd0);
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // Asynchronous clear truncates any sync pulse in progress and restarts the raster at (0,0).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hcnt_q        <= 11'd0;
            vcnt_q        <= 11'd0;
            den_q         <= 1'b0;
            x_q           <= 11'd0;
            y_q           <= 11'd0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            den_q         <= den_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign lcd.DEN         = den_q;
    assign lcd.X           = x_q;
    assign lcd.Y           = y_q;
    assign lcd.HSYNC_N     = hsync_n_q;
    assign lcd.VSYNC_N     = vsync_n_q;
    assign lcd.LINE_END    = line_end_q;
    assign lcd.FRAME_START = frame_start_q;
    assign lcd.FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: default, small and minimal raster builds against an arithmetic
// raster model, with randomized asynchronous reset placed inside a horizontal sync pulse.
module tb_lcd_timing_gen;

    typedef struct packed {
        logic        den;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs_n;
        logic        vs_n;
        logic        le;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    lcd_timing_gen_if a_if ();
    lcd_timing_gen_if b_if ();
    lcd_timing_gen_if c_if ();

    lcd_timing_gen u_dut_a (
        .CLK  (clk),
        .nRST (rst_n),
        .lcd  (a_if)
    );

    lcd_timing_gen #(
        .LCD_WIDTH (8), .LCD_HEIGHT (6), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_dut_b (
        .CLK  (clk),
        .nRST (rst_n),
        .lcd  (b_if)
    );

    lcd_timing_gen #(
        .LCD_WIDTH (1), .LCD_HEIGHT (1), .H_FP (0), .H_SYNC (0), .H_BP (0),
        .V_FP (0), .V_SYNC (0), .V_BP (0)
    ) u_dut_c (
        .CLK  (clk),
        .nRST (rst_n),
        .lcd  (c_if)
    );

    out_t obs_a, obs_b, obs_c;
    int   vs_low_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edge k (k>=1) after reset release shows raster index k-1.
    function automatic out_t raster_model(input int w, input int h, input int hfp, input int hsy,
                                          input int hbp, input int vfp, input int vsy,
                                          input int vbp, input longint k);
        out_t   e;
        longint ht  = longint'(w + hfp + hsy + hbp);
        longint vt  = longint'(h + vfp + vsy + vbp);
        longint idx = k - 1;
        longint hh  = idx % ht;
        longint vv  = (idx / ht) % vt;
        longint fr  = idx / (ht * vt) + 1;
        e.den  = (hh < w) && (vv < h);
        e.x    = e.den ? 11'(hh) : 11'd0;
        e.y    = e.den ? 11'(vv) : 11'd0;
        e.hs_n = !((hh >= w + hfp) && (hh < w + hfp + hsy));
        e.vs_n = !((vv >= h + vfp) && (vv < h + vfp + vsy));
        e.le   = (hh == ht - 1);
        e.fs   = (hh == 0) && (vv == 0);
        e.fc   = 16'(fr);
        return e;
    endfunction

    task automatic check_out(input string name, input out_t obs, input out_t exp);
        check_eq({name, "_den"}, 32'(obs.den), 32'(exp.den));
        check_eq({name, "_x"}, 32'(obs.x), 32'(exp.x));
        check_eq({name, "_y"}, 32'(obs.y), 32'(exp.y));
        check_eq({name, "_hsync_n"}, 32'(obs.hs_n), 32'(exp.hs_n));
        check_eq({name, "_vsync_n"}, 32'(obs.vs_n), 32'(exp.vs_n));
        check_eq({name, "_line_end"}, 32'(obs.le), 32'(exp.le));
        check_eq({name, "_frame_start"}, 32'(obs.fs), 32'(exp.fs));
        check_eq({name, "_frame_cnt"}, 32'(obs.fc), 32'(exp.fc));
    endtask

    task automatic sample();
        obs_a = {a_if.DEN, a_if.X, a_if.Y, a_if.HSYNC_N, a_if.VSYNC_N, a_if.LINE_END,
                 a_if.FRAME_START, a_if.FRAME_CNT};
        obs_b = {b_if.DEN, b_if.X, b_if.Y, b_if.HSYNC_N, b_if.VSYNC_N, b_if.LINE_END,
                 b_if.FRAME_START, b_if.FRAME_CNT};
        obs_c = {c_if.DEN, c_if.X, c_if.Y, c_if.HSYNC_N, c_if.VSYNC_N, c_if.LINE_END,
                 c_if.FRAME_START, c_if.FRAME_CNT};
    endtask

    task automatic check_reset(input string tag);
        out_t r;
        r = '{den: 1'b0, x: 11'd0, y: 11'd0, hs_n: 1'b1, vs_n: 1'b1, le: 1'b0, fs: 1'b0,
              fc: 16'd0};
        sample();
        check_out({tag, "_a"}, obs_a, r);
        check_out({tag, "_b"}, obs_b, r);
        check_out({tag, "_c"}, obs_c, r);
    endtask

    // Hand-derived landmarks of the default 535x300 raster.
    task automatic spec_points(input longint k);
        if (k == 1) begin
            check_eq("t1_den", 32'(a_if.DEN), 32'd1);
            check_eq("t1_x0", 32'(a_if.X), 32'd0);
            check_eq("t1_y0", 32'(a_if.Y), 32'd0);
            check_eq("t1_frame_start", 32'(a_if.FRAME_START), 32'd1);
            check_eq("t1_frame_cnt", 32'(a_if.FRAME_CNT), 32'd1);
        end
        if (k == 480) check_eq("t1_x479", 32'(a_if.X), 32'd479);
        if (k == 481) begin
            check_eq("t1_den_off", 32'(a_if.DEN), 32'd0);
            check_eq("t1_x_off", 32'(a_if.X), 32'd0);
        end
        if (k >= 1 && k <= 535) begin
            check_eq("t2_hsync_n", 32'(a_if.HSYNC_N), (k >= 489 && k <= 492) ? 32'd0 : 32'd1);
            check_eq("t2_line_end", 32'(a_if.LINE_END), (k == 535) ? 32'd1 : 32'd0);
        end
        if (k == 536) begin
            check_eq("t3_den", 32'(a_if.DEN), 32'd1);
            check_eq("t3_x0", 32'(a_if.X), 32'd0);
            check_eq("t3_y1", 32'(a_if.Y), 32'd1);
        end
    endtask

    task automatic step_and_check(input longint k);
        @(posedge clk);
        #1;
        sample();
        check_out("a", obs_a, raster_model(480, 280, 8, 4, 43, 4, 4, 12, k));
        check_out("b", obs_b, raster_model(8, 6, 2, 3, 2, 1, 2, 1, k));
        if (k % 1000 == 1 || k >= 65534) begin
            check_out("c", obs_c, raster_model(1, 1, 0, 0, 0, 0, 0, 0, k));
        end
        spec_points(k);
        if (k <= 150 && !b_if.VSYNC_N) vs_low_b++;
        if (k == 150) check_eq("b_vsync_low_edges", 32'(vs_low_b), 32'd30);
        if (k == 65535) check_eq("c_frame_cnt_max", 32'(c_if.FRAME_CNT), 32'd65535);
        if (k == 65536) check_eq("c_frame_cnt_wrap", 32'(c_if.FRAME_CNT), 32'd0);
    endtask

    initial begin
        int     line_sel;
        int     sync_off;
        int     hold;
        longint target;

        line_sel = int'($urandom_range(1, 4));
        sync_off = int'($urandom_range(0, 3));
        hold     = int'($urandom_range(1, 5));
        target   = longint'(line_sel * 535 + 489 + sync_off);

        rst_n    = 1'b0;
        vs_low_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (longint k = 1; k <= target; k++) step_and_check(k);
        check_eq("a_in_hsync_before_reset", 32'(a_if.HSYNC_N), 32'd0);

        // Assert reset between edges; outputs must clear without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        repeat (hold) @(posedge clk);
        #1;
        check_reset("held");
        @(negedge clk);
        rst_n    = 1'b1;
        vs_low_b = 0;

        for (longint k = 1; k <= 65540; k++) step_and_check(k);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
